fp_issue_arbiter: RTL and testbench

//  Shares one fp_unit between NUM_REQ requesters (e.g. integer pipe, vector lane, debug port).

---
 rtl/fp_issue_arbiter_pkg.sv | 57 +++++
 rtl/fp_issue_arbiter_tag_fifo.sv | 62 ++++++
 rtl/fp_issue_arbiter.sv | 156 +++++++++++++++
 tb/tb_fp_issue_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_issue_arbiter_pkg.sv
// Types shared by the fp_unit issue arbiter: fp_unit request/response structs, the issue FSM
// state and small helpers for tag width and op classification.
package fp_issue_arbiter_pkg;

  typedef struct packed {
    logic       fmadd;
    logic       fmsub;
    logic       fnmsub;
    logic       fnmadd;
    logic       fadd;
    logic       fsub;
    logic       fmul;
    logic       fdiv;
    logic       fsqrt;
    logic       fsgnj;
    logic       fcmp;
    logic       fmax;
    logic       fclass;
    logic       fmv_i2f;
    logic       fmv_f2i;
    logic       fcvt_i2f;
    logic       fcvt_f2i;
    logic [1:0] fcvt_op;
  } fp_operation_type;

  typedef struct packed {
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      data3;
    fp_operation_type op;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    logic             enable;
  } fp_exe_in_type;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_exe_out_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PIPE = 2'd1,
    ITER = 2'd2
  } fp_issue_state_t;

  // Tag width never collapses to zero bits.
  function automatic int unsigned fp_tag_w(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic logic is_iter_op(input fp_operation_type op);
    return op.fdiv | op.fsqrt;
  endfunction

endpackage

// File: rtl/fp_issue_arbiter_tag_fifo.sv
// Synchronous in-order FIFO of requester tags; one entry per fp_unit op in flight.
module fp_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [TAG_W-1:0]       push_tag,
  input  logic                   pop,
  output logic [TAG_W-1:0]       tag,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign tag     = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_issue_arbiter.sv
// Round-robin issue arbiter sharing one fp_unit between NUM_REQ requesters, with in-order
// result routing. Define FP_ISSUE_ARB_PERF_EN to add per-requester grant and stall counters.
module fp_issue_arbiter
  import fp_issue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                           reset,
  input  logic                           clock,
  input  logic           [NUM_REQ-1:0]   req_valid,
  output logic           [NUM_REQ-1:0]   req_ready,
  input  fp_exe_in_type  [NUM_REQ-1:0]   req_data,
  output fp_exe_in_type                  fpu_i,
  input  fp_exe_out_type                 fpu_o,
  output logic           [NUM_REQ-1:0]   rsp_valid,
  output logic           [31:0]          rsp_result,
  output logic           [4:0]           rsp_flags,
  output logic                           err
`ifdef FP_ISSUE_ARB_PERF_EN
  ,
  output logic           [NUM_REQ-1:0][31:0] perf_grant,
  output logic           [31:0]              perf_stall
`endif
);

  localparam int unsigned FP_TAG_W = fp_tag_w(NUM_REQ);
  localparam int unsigned CNT_W    = $clog2(MAX_INFLIGHT) + 1;

  fp_issue_state_t     state;
  logic [FP_TAG_W-1:0] rr_ptr;
  logic [FP_TAG_W-1:0] win_idx;
  logic [FP_TAG_W-1:0] cand_idx;
  logic                win_found;
  logic                win_iter;
  logic                can_issue;
  logic                grant;
  logic                retire;

  logic [FP_TAG_W-1:0] fifo_tag;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  fp_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .TAG_W (FP_TAG_W)
  ) u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (grant),
    .push_tag (win_idx),
    .pop      (retire),
    .tag      (fifo_tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // The rr winner is the first valid requester at or after rr_ptr; if it cannot issue it is
  // held rather than skipped, so a blocked div/sqrt keeps its turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand_idx = FP_TAG_W'((int'(rr_ptr) + i) % int'(NUM_REQ));
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign win_iter = is_iter_op(req_data[win_idx].op);

  always_comb begin
    can_issue = 1'b0;
    unique case (state)
      IDLE:    can_issue = 1'b1;
      PIPE:    can_issue = !win_iter && !fifo_full;
      ITER:    can_issue = 1'b0;
      default: can_issue = 1'b0;
    endcase
  end

  assign grant     = reset & win_found & can_issue;
  assign req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;
  assign retire    = fpu_o.ready & ~fifo_empty;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      fpu_i      <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      err        <= 1'b0;
    end else begin
      fpu_i.enable <= 1'b0;
      if (grant) begin
        fpu_i        <= req_data[win_idx];
        fpu_i.enable <= 1'b1;
        rr_ptr       <= (win_idx == FP_TAG_W'(NUM_REQ - 1)) ? '0 : win_idx + FP_TAG_W'(1);
      end

      rsp_valid <= '0;
      if (fpu_o.ready) begin
        if (fifo_empty) begin
          err <= 1'b1;
        end else begin
          rsp_valid  <= NUM_REQ'(1) << fifo_tag;
          rsp_result <= fpu_o.result;
          rsp_flags  <= fpu_o.flags;
        end
      end

      unique case (state)
        IDLE: begin
          if (grant) begin
            state <= win_iter ? ITER : PIPE;
          end
        end
        PIPE: begin
          if (retire && (fifo_count == CNT_W'(1)) && !grant) begin
            state <= IDLE;
          end
        end
        ITER: begin
          if (retire) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP_ISSUE_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_grant <= '0;
      perf_stall <= '0;
    end else begin
      if (grant) begin
        perf_grant[win_idx] <= perf_grant[win_idx] + 32'd1;
      end
      if (|req_valid && !grant) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_issue_arbiter.sv
// Bench for fp_issue_arbiter: a fake fp_unit with fixed latencies, a queue-based model of the
// issue rules checked every cycle, and directed scenarios with literal expectations.
module tb_fp_issue_arbiter;
  import fp_issue_arbiter_pkg::*;

  localparam int NUM_REQ      = 2;
  localparam int MAX_INFLIGHT = 4;
  localparam int PIPE_LAT     = 4;
  localparam int ITER_LAT     = 8;

  logic                              clock = 1'b0;
  logic                              reset = 1'b0;
  logic           [NUM_REQ-1:0]      req_valid = '0;
  logic           [NUM_REQ-1:0]      req_ready;
  fp_exe_in_type  [NUM_REQ-1:0]      req_data = '0;
  fp_exe_in_type                     fpu_i;
  fp_exe_out_type                    fpu_o = '0;
  logic           [NUM_REQ-1:0]      rsp_valid;
  logic           [31:0]             rsp_result;
  logic           [4:0]              rsp_flags;
  logic                              err;
`ifdef FP_ISSUE_ARB_PERF_EN
  logic           [NUM_REQ-1:0][31:0] perf_grant;
  logic           [31:0]              perf_stall;
`endif

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  bit force_ready = 1'b0;

  fp_issue_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) dut (
    .reset      (reset),
    .clock      (clock),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .fpu_i      (fpu_i),
    .fpu_o      (fpu_o),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .err        (err)
`ifdef FP_ISSUE_ARB_PERF_EN
    ,
    .perf_grant (perf_grant),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Fake fp_unit results: a few exact IEEE cases, otherwise an operand-derived pattern.
  function automatic fp_exe_out_type fpu_fn(input fp_exe_in_type d);
    fp_exe_out_type o;
    o = '0;
    o.ready = 1'b1;
    if (d.op.fadd && d.data1 == 32'h3F800000 && d.data2 == 32'h40000000) begin
      o.result = 32'h40400000;
    end else if (d.op.fmul && d.data1 == 32'h40000000 && d.data2 == 32'h40400000) begin
      o.result = 32'h40C00000;
    end else if (d.op.fdiv && d.data1 == 32'h3F800000 && d.data2 == 32'h00000000) begin
      o.result = 32'h7F800000;
      o.flags  = 5'b01000;
    end else begin
      o.result = d.data1 ^ d.data2 ^ 32'hA5A50F0F;
    end
    return o;
  endfunction

  function automatic fp_exe_in_type mk(input int op, input logic [31:0] a, input logic [31:0] b);
    fp_exe_in_type d;
    d = '0;
    d.data1 = a;
    d.data2 = b;
    case (op)
      0:       d.op.fadd = 1'b1;
      1:       d.op.fmul = 1'b1;
      2:       d.op.fdiv = 1'b1;
      default: d.op.fsqrt = 1'b1;
    endcase
    d.enable = 1'b1; // must be ignored by the arbiter
    return d;
  endfunction

  // ---------------- fake fp_unit ----------------
  typedef struct { logic [31:0] res; logic [4:0] fl; int due; } fq_t;
  fq_t            fq[$];
  fq_t            f_e;
  fp_exe_out_type f_r;
  int             fcyc = 0;

  always begin
    @(posedge clock);
    fcyc++;
    if (!reset) begin
      fq.delete();
    end else if (fpu_i.enable) begin
      f_r     = fpu_fn(fpu_i);
      f_e.res = f_r.result;
      f_e.fl  = f_r.flags;
      f_e.due = fcyc + ((fpu_i.op.fdiv | fpu_i.op.fsqrt) ? ITER_LAT : PIPE_LAT) - 1;
      fq.push_back(f_e);
    end
    #2;
    fpu_o = '0;
    if (force_ready) begin
      fpu_o.result = 32'hDEADBEEF;
      fpu_o.flags  = 5'h1F;
      fpu_o.ready  = 1'b1;
    end else if (fq.size() > 0 && fq[0].due <= fcyc) begin
      fpu_o.result = fq[0].res;
      fpu_o.flags  = fq[0].fl;
      fpu_o.ready  = 1'b1;
      void'(fq.pop_front());
    end
  end

  // ---------------- model + per-cycle compare ----------------
  int             m_tag[$];
  bit             m_it[$];
  int             m_rr = 0;
  bit             m_err = 1'b0;
  bit             m_en = 1'b0;
  fp_exe_in_type  m_data = '0;
  logic [NUM_REQ-1:0] m_rv = '0;
  logic [31:0]    m_res = '0;
  logic [4:0]     m_fl = '0;
  int             m_pg[NUM_REQ];
  int             m_ps = 0;

  typedef struct { int tag; int cyc; } glog_t;
  typedef struct { int tag; logic [31:0] res; logic [4:0] fl; int cyc; } rlog_t;
  glog_t glog[$];
  rlog_t rlog[$];
  glog_t g_e;
  rlog_t r_e;
  int    mcyc = 0;

  int                 w;
  int                 cand;
  bit                 cand_it;
  bit                 busy_it;
  logic [NUM_REQ-1:0] exp_ready;

  always @(negedge clock) begin
    if (mon_en) begin
      mcyc++;
      w = -1;
      cand = -1;
      cand_it = 1'b0;
      busy_it = 1'b0;
      foreach (m_it[k]) if (m_it[k]) busy_it = 1'b1;
      if (reset) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (cand < 0 && req_valid[(m_rr + k) % NUM_REQ]) cand = (m_rr + k) % NUM_REQ;
        end
        if (cand >= 0) begin
          cand_it = req_data[cand].op.fdiv | req_data[cand].op.fsqrt;
          if (m_tag.size() == 0) w = cand;
          else if (!cand_it && !busy_it && m_tag.size() < MAX_INFLIGHT) w = cand;
        end
      end
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;

      chk("req_ready", req_ready, exp_ready);
      chk("fpu_enable", fpu_i.enable, m_en);
      if (m_en) chk("fpu_data", fpu_i, m_data);
      chk("rsp_valid", rsp_valid, m_rv);
      if (m_rv != '0) begin
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_flags", rsp_flags, m_fl);
      end
      chk("err", err, m_err);
`ifdef FP_ISSUE_ARB_PERF_EN
      for (int k = 0; k < NUM_REQ; k++) chk("perf_grant", perf_grant[k], m_pg[k]);
      chk("perf_stall", perf_stall, m_ps);
`endif

      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_ready[k] && req_valid[k]) begin
          g_e.tag = k;
          g_e.cyc = mcyc;
          glog.push_back(g_e);
        end
        if (rsp_valid[k]) begin
          r_e.tag = k;
          r_e.res = rsp_result;
          r_e.fl  = rsp_flags;
          r_e.cyc = mcyc;
          rlog.push_back(r_e);
        end
      end

      if (!reset) begin
        m_tag.delete();
        m_it.delete();
        m_rr = 0;
        m_err = 1'b0;
        m_en = 1'b0;
        m_rv = '0;
        m_ps = 0;
        foreach (m_pg[k]) m_pg[k] = 0;
      end else begin
        m_rv = '0;
        if (fpu_o.ready) begin
          if (m_tag.size() == 0) begin
            m_err = 1'b1;
          end else begin
            m_rv[m_tag[0]] = 1'b1;
            m_res = fpu_o.result;
            m_fl  = fpu_o.flags;
            void'(m_tag.pop_front());
            void'(m_it.pop_front());
          end
        end
        m_en = (w >= 0);
        if (w >= 0) begin
          m_data = req_data[w];
          m_data.enable = 1'b1;
          m_tag.push_back(w);
          m_it.push_back(cand_it);
          m_rr = (w + 1) % NUM_REQ;
          m_pg[w]++;
        end else if (|req_valid) begin
          m_ps++;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_logs();
    glog.delete();
    rlog.delete();
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    drain(2);
    reset = 1'b1;
  endtask

  task automatic issue(input int r, input fp_exe_in_type d);
    bit ok;
    ok = 1'b0;
    req_valid[r] = 1'b1;
    req_data[r]  = d;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clock);
      ok = req_ready[r];
      tick();
    end
    req_valid[r] = 1'b0;
    chk("issue_granted", ok, 1'b1);
  endtask

  localparam logic [31:0] T4_RES [5] = '{32'hA5A51F0F, 32'hA5A51F0E, 32'hA5A51F0D,
                                          32'hA5A51F0C, 32'hA5A51F0B};

  initial begin
    drain(2);
    mon_en = 1'b1;
    @(negedge clock);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_fpu_i", fpu_i, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_err", err, 0);
    tick();
    reset = 1'b1;
    tick();

    // 1: single fadd from req0
    clear_logs();
    issue(0, mk(0, 32'h3F800000, 32'h40000000));
    drain(12);
    chk("t1_rsp_count", rlog.size(), 1);
    if (rlog.size() >= 1) begin
      chk("t1_rsp_tag", rlog[0].tag, 0);
      chk("t1_rsp_result", rlog[0].res, 32'h40400000);
      chk("t1_rsp_flags", rlog[0].fl, 5'b00000);
    end

    // 2: both requesters fmul continuously
    reset_dut();
    clear_logs();
    req_data[0] = mk(1, 32'h40000000, 32'h40400000);
    req_data[1] = mk(1, 32'h40000000, 32'h40400000);
    req_valid   = 2'b11;
    drain(16);
    req_valid   = 2'b00;
    drain(20);
    chk("t2_enough_grants", glog.size() >= 4, 1'b1);
    if (glog.size() >= 4) begin
      chk("t2_grant0", glog[0].tag, 0);
      chk("t2_grant1", glog[1].tag, 1);
      chk("t2_grant2", glog[2].tag, 0);
      chk("t2_grant3", glog[3].tag, 1);
    end
    chk("t2_rsp_count", rlog.size(), glog.size());
    foreach (rlog[k]) begin
      if (k < glog.size()) chk("t2_rsp_order", rlog[k].tag, glog[k].tag);
      chk("t2_rsp_result", rlog[k].res, 32'h40C00000);
    end

    // 3: fdiv from req1 blocks a following fadd from req0
    clear_logs();
    issue(1, mk(2, 32'h3F800000, 32'h00000000));
    issue(0, mk(0, 32'h3F800000, 32'h40000000));
    drain(12);
    chk("t3_grant_count", glog.size(), 2);
    chk("t3_rsp_count", rlog.size(), 2);
    if (glog.size() >= 2 && rlog.size() >= 2) begin
      chk("t3_div_tag", rlog[0].tag, 1);
      chk("t3_div_result", rlog[0].res, 32'h7F800000);
      chk("t3_div_flags", rlog[0].fl, 5'b01000);
      chk("t3_add_after_div", glog[1].cyc >= rlog[0].cyc, 1'b1);
      chk("t3_add_tag", rlog[1].tag, 0);
      chk("t3_add_result", rlog[1].res, 32'h40400000);
    end

    // 4: five back-to-back fadds against a 4-deep tag FIFO
    clear_logs();
    for (int k = 0; k < 5; k++) issue(0, mk(0, 32'h00001000 + k, 32'h0));
    drain(15);
    chk("t4_grant_count", glog.size(), 5);
    chk("t4_rsp_count", rlog.size(), 5);
    if (glog.size() == 5 && rlog.size() >= 1) begin
      chk("t4_first4_b2b", glog[3].cyc - glog[0].cyc, 3);
      chk("t4_stall_gap", glog[4].cyc - glog[3].cyc >= 2, 1'b1);
      chk("t4_fifth_after_retire", glog[4].cyc >= rlog[0].cyc, 1'b1);
    end
    foreach (rlog[k]) begin
      if (k < 5) chk("t4_rsp_result", rlog[k].res, T4_RES[k]);
    end

    // 5: spurious ready while idle, then reset
    clear_logs();
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    tick();
    @(negedge clock);
    chk("t5_err_set", err, 1'b1);
    chk("t5_no_rsp", rlog.size(), 0);
    tick();
    reset_dut();
    @(negedge clock);
    chk("t5_err_clear", err, 1'b0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_rsp_result", rsp_result, 0);
    chk("t5_rsp_flags", rsp_flags, 0);
    chk("t5_fpu_i", fpu_i, 0);
    chk("t5_req_ready", req_ready, 0);
    tick();

    // 6: reset with three ops in flight
    clear_logs();
    for (int k = 0; k < 3; k++) issue(0, mk(0, 32'h00002000 + k, 32'h0));
    reset_dut();
    @(negedge clock);
    chk("t6_fifo_empty", dut.fifo_empty, 1'b1);
    chk("t6_state_idle", dut.state == IDLE, 1'b1);
`ifdef FP_ISSUE_ARB_PERF_EN
    chk("t6_perf_grant0", perf_grant[0], 0);
    chk("t6_perf_stall", perf_stall, 0);
`endif
    tick();
    drain(10);
    chk("t6_no_stale_rsp", rlog.size(), 0);
    clear_logs();
    issue(0, mk(0, 32'h3F800000, 32'h40000000));
    drain(12);
    chk("t6_rsp_count", rlog.size(), 1);
    if (rlog.size() >= 1) begin
      chk("t6_rsp_tag", rlog[0].tag, 0);
      chk("t6_rsp_result", rlog[0].res, 32'h40400000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
